// File: rtl/ltl_ctrl_pkg.sv
// Shared types and defaults for the LTL monitor cluster controller.
// Optional halt-on-violation mode: LTL_CTRL_HALT_ON_VIOLATION_EN.
package ltl_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FLUSH
    } state_t;

    localparam int DEF_NUM_PROPS    = 9;
    localparam int DEF_SYM_W        = 8;
    localparam int DEF_TS_W         = 16;
    localparam int DEF_FLUSH_CYCLES = 2;
    localparam int PROP_ID_W        = $clog2(DEF_NUM_PROPS);

endpackage

// File: rtl/ltl_rr_arbiter.sv
// Round-robin pick over pending violations, searching from ptr+1 upward.
// Purely combinational; grant is one-hot, idx is its binary index.
module ltl_rr_arbiter
    import ltl_ctrl_pkg::*;
#(
    parameter int N  = DEF_NUM_PROPS,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    function automatic logic [IW-1:0] wrap(input int k);
        return IW'(k % N);
    endfunction

    always_comb begin
        idx = '0;
        any = |req;
        // Walk farthest-first so the nearest requester after ptr wins.
        for (int i = N; i >= 1; i--) begin
            if (req[wrap(int'(ptr) + i)]) begin
                idx = wrap(int'(ptr) + i);
            end
        end
        grant = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/ltl_monitor_ctrl.sv
// Sequencer and violation arbiter for one LTL monitor cluster.
// Define LTL_CTRL_HALT_ON_VIOLATION_EN to stall symbols while reports pend.
module ltl_monitor_ctrl
    import ltl_ctrl_pkg::*;
#(
    parameter int NUM_PROPS    = DEF_NUM_PROPS,
    parameter int SYM_W        = DEF_SYM_W,
    parameter int TS_W         = DEF_TS_W,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    localparam int ID_W        = $clog2(NUM_PROPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 flush_req,
    input  logic                 sym_valid,
    output logic                 sym_ready,
    input  logic [SYM_W-1:0]     sym_data,
    output logic                 mon_run,
    output logic                 mon_reset,
    output logic [SYM_W-1:0]     mon_symbols,
    input  logic [NUM_PROPS-1:0] mon_flags,
    output logic                 rpt_valid,
    input  logic                 rpt_ready,
    output logic [ID_W-1:0]      rpt_id,
    output logic [TS_W-1:0]      rpt_ts,
    output logic                 busy,
    output logic                 overflow
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    state_t              state;
    logic [FC_W-1:0]     fcnt;
    logic                drain_cnt;
    logic [TS_W-1:0]     ts_cnt;
    logic [TS_W-1:0]     s1_ts;
    logic [TS_W-1:0]     s2_ts;
    logic                s2_valid;
    logic [NUM_PROPS-1:0] pending;
    logic [TS_W-1:0]     ts_store [NUM_PROPS];
    logic [ID_W-1:0]     rr_ptr;

    logic                 flushing;
    logic                 accept;
    logic                 hs;
    logic                 halt;
    logic [NUM_PROPS-1:0] clr;
    logic [NUM_PROPS-1:0] pend_hs;
    logic [NUM_PROPS-1:0] cap;
    logic [NUM_PROPS-1:0] set_new;
    logic                 ovf_evt;
    logic [ID_W-1:0]      arb_ptr;
    logic [NUM_PROPS-1:0] gnt;
    logic [ID_W-1:0]      gnt_idx;
    logic                 gnt_any;
    logic [TS_W-1:0]      win_ts;

`ifdef LTL_CTRL_HALT_ON_VIOLATION_EN
    assign halt = |pending;
`else
    assign halt = 1'b0;
`endif

    assign flushing  = flush_req | (state == FLUSH);
    assign sym_ready = (state == RUN) & ~halt & ~flush_req;
    assign accept    = sym_valid & sym_ready;
    assign hs        = rpt_valid & rpt_ready;
    assign busy      = (state != IDLE) | (|pending);

    // Capture after the handshake clear so a same-cycle re-flag is no loss.
    assign clr     = hs ? (NUM_PROPS'(1) << rpt_id) : '0;
    assign pend_hs = pending & ~clr;
    assign cap     = s2_valid ? mon_flags : '0;
    assign set_new = cap & ~pend_hs;
    assign ovf_evt = |(cap & pend_hs);
    assign arb_ptr = hs ? rpt_id : rr_ptr;

    ltl_rr_arbiter #(
        .N (NUM_PROPS),
        .IW(ID_W)
    ) u_arb (
        .req  (pend_hs),
        .ptr  (arb_ptr),
        .grant(gnt),
        .idx  (gnt_idx),
        .any  (gnt_any)
    );

    always_comb begin
        win_ts = '0;
        for (int i = 0; i < NUM_PROPS; i++) begin
            if (gnt[i]) win_ts |= ts_store[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mon_reset <= 1'b1;
            fcnt      <= '0;
            drain_cnt <= 1'b0;
        end else if (flush_req) begin
            state     <= FLUSH;
            mon_reset <= 1'b1;
            fcnt      <= '0;
        end else begin
            mon_reset <= 1'b0;
            unique case (state)
                IDLE: if (enable) state <= RUN;
                RUN: begin
                    if (!enable) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt && !mon_run && !s2_valid) state <= IDLE;
                    else drain_cnt <= 1'b1;
                end
                FLUSH: begin
                    if (fcnt == FC_W'(FLUSH_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        fcnt      <= fcnt + FC_W'(1);
                        mon_reset <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mon_run     <= 1'b0;
            mon_symbols <= '0;
            ts_cnt      <= '0;
            s1_ts       <= '0;
            s2_ts       <= '0;
            s2_valid    <= 1'b0;
        end else if (flushing) begin
            mon_run  <= 1'b0;
            s2_valid <= 1'b0;
            ts_cnt   <= '0;
        end else begin
            mon_run  <= accept;
            s2_valid <= mon_run;
            s2_ts    <= s1_ts;
            if (accept) begin
                mon_symbols <= sym_data;
                s1_ts       <= ts_cnt;
                ts_cnt      <= ts_cnt + TS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PROPS; i++) ts_store[i] <= '0;
        end else if (!flushing) begin
            for (int i = 0; i < NUM_PROPS; i++) begin
                if (set_new[i]) ts_store[i] <= s2_ts;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            rr_ptr    <= '0;
            overflow  <= 1'b0;
            rpt_valid <= 1'b0;
            rpt_id    <= '0;
            rpt_ts    <= '0;
        end else if (flushing) begin
            pending   <= '0;
            rr_ptr    <= '0;
            overflow  <= 1'b0;
            rpt_valid <= 1'b0;
        end else begin
            pending <= pend_hs | cap;
            if (ovf_evt) overflow <= 1'b1;
            if (hs) rr_ptr <= rpt_id;
            if (!rpt_valid || hs) begin
                rpt_valid <= gnt_any;
                if (gnt_any) begin
                    rpt_id <= gnt_idx;
                    rpt_ts <= win_ts;
                end
            end
        end
    end

endmodule

// File: tb/tb_ltl_monitor_ctrl.sv
// Directed bench for ltl_monitor_ctrl with a table-driven cluster model.
// Honours LTL_CTRL_HALT_ON_VIOLATION_EN for the stall expectations.
module tb_ltl_monitor_ctrl;

`ifdef LTL_CTRL_HALT_ON_VIOLATION_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        flush_req;
    logic        sym_valid;
    logic        sym_ready;
    logic [7:0]  sym_data;
    logic        mon_run;
    logic        mon_reset;
    logic [7:0]  mon_symbols;
    logic [8:0]  mon_flags = '0;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [3:0]  rpt_id;
    logic [15:0] rpt_ts;
    logic        busy;
    logic        overflow;

    logic [8:0]  flag_tab [0:255];
    int          total = 0;
    int          bad = 0;

    ltl_monitor_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .flush_req  (flush_req),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_data   (sym_data),
        .mon_run    (mon_run),
        .mon_reset  (mon_reset),
        .mon_symbols(mon_symbols),
        .mon_flags  (mon_flags),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_id     (rpt_id),
        .rpt_ts     (rpt_ts),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Cluster stand-in: flags appear the cycle after a run strobe.
    always @(posedge clk) mon_flags <= mon_run ? flag_tab[mon_symbols] : '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!sym_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, sym_ready, 1);
    endtask

    task automatic send(input logic [7:0] s, input int cnt);
        wait_ready("send");
        sym_valid = 1'b1;
        sym_data  = s;
        repeat (cnt) @(posedge clk);
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    task automatic wait_rpt(input string tag);
        int n = 0;
        @(negedge clk);
        while (!rpt_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, rpt_valid, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) flag_tab[i] = '0;
        flag_tab[8'h22] = 9'h008;
        flag_tab[8'h38] = 9'h100;
        flag_tab[8'h45] = 9'h111;
        flag_tab[8'h46] = 9'h011;
        flag_tab[8'h52] = 9'h004;
        flag_tab[8'h63] = 9'h007;
        flag_tab[8'h71] = 9'h040;
        flag_tab[8'h85] = 9'h020;
        flag_tab[8'h73] = 9'h002;
        flag_tab[8'h72] = 9'h080;

        reset = 1'b1; enable = 1'b0; flush_req = 1'b0;
        sym_valid = 1'b0; sym_data = '0; rpt_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sym_ready", sym_ready, 0);
        chk("rst_mon_run", mon_run, 0);
        chk("rst_mon_reset", mon_reset, 1);
        chk("rst_mon_symbols", mon_symbols, 0);
        chk("rst_rpt_valid", rpt_valid, 0);
        chk("rst_rpt_id", rpt_id, 0);
        chk("rst_rpt_ts", rpt_ts, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mon_reset_release", mon_reset, 0);

        // Single violation on the second symbol
        enable = 1'b1;
        send(8'h11, 1);
        send(8'h22, 1);
        chk("t1_mon_run", mon_run, 1);
        chk("t1_mon_symbols", mon_symbols, 8'h22);
        wait_rpt("t1");
        chk("t1_id", rpt_id, 3);
        chk("t1_ts", rpt_ts, 1);
        chk("t1_busy", busy, 1);
        rpt_ready = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        rpt_ready = 1'b0;
        chk("t1_cleared", rpt_valid, 0);
        repeat (4) @(negedge clk);
        chk("t1_busy_low", busy, 0);

        // Round-robin bursts, pointer parked on 8 first
        enable = 1'b1;
        rpt_ready = 1'b1;
        send(8'h38, 1);
        wait_rpt("t2a");
        chk("t2a_id", rpt_id, 8);
        chk("t2a_ts", rpt_ts, 2);
        @(negedge clk);
        chk("t2a_done", rpt_valid, 0);
        send(8'h45, 1);
        wait_rpt("t2b");
        chk("t2b_id0", rpt_id, 0);
        chk("t2b_ts", rpt_ts, 3);
        @(negedge clk);
        chk("t2b_v4", rpt_valid, 1);
        chk("t2b_id4", rpt_id, 4);
        @(negedge clk);
        chk("t2b_v8", rpt_valid, 1);
        chk("t2b_id8", rpt_id, 8);
        @(negedge clk);
        chk("t2b_done", rpt_valid, 0);
        send(8'h46, 1);
        wait_rpt("t2c");
        chk("t2c_id0", rpt_id, 0);
        chk("t2c_ts", rpt_ts, 4);
        @(negedge clk);
        chk("t2c_id4", rpt_id, 4);
        chk("t2c_v4", rpt_valid, 1);
        @(negedge clk);
        chk("t2c_done", rpt_valid, 0);
        rpt_ready = 1'b0;

        // Repeat violation while stalled -> overflow, first ts kept
        send(8'h52, 2);
        wait_rpt("t3");
        chk("t3_id", rpt_id, 2);
        chk("t3_ts", rpt_ts, 5);
        repeat (3) @(negedge clk);
        chk("t3_overflow", overflow, 1);
        chk("t3_hold_v", rpt_valid, 1);
        chk("t3_hold_id", rpt_id, 2);
        chk("t3_hold_ts", rpt_ts, 5);
        rpt_ready = 1'b1;
        @(negedge clk);
        rpt_ready = 1'b0;
        chk("t3_cleared", rpt_valid, 0);
        chk("t3_sticky", overflow, 1);

        // Flush with three violations pending mid-stream
        send(8'h63, 1);
        sym_valid = 1'b1;
        sym_data = 8'h00;
        wait_rpt("t4");
        chk("t4_id", rpt_id, 0);
        chk("t4_ts", rpt_ts, 7);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        chk("t4_rpt_drop", rpt_valid, 0);
        chk("t4_mon_reset1", mon_reset, 1);
        chk("t4_mon_run", mon_run, 0);
        chk("t4_sym_ready", sym_ready, 0);
        chk("t4_ovf_clr", overflow, 0);
        @(negedge clk);
        chk("t4_mon_reset2", mon_reset, 1);
        @(negedge clk);
        sym_valid = 1'b0;
        chk("t4_mon_reset_end", mon_reset, 0);
        chk("t4_idle", busy, 0);
        rpt_ready = 1'b1;
        send(8'h71, 1);
        wait_rpt("t4b");
        chk("t4b_id", rpt_id, 6);
        chk("t4b_ts0", rpt_ts, 0);
        @(negedge clk);
        chk("t4b_done", rpt_valid, 0);
        rpt_ready = 1'b0;

        // Symbol stall while a report pends (mode dependent)
        send(8'h85, 1);
        wait_rpt("t6");
        chk("t6_id", rpt_id, 5);
        chk("t6_ts", rpt_ts, 1);
        chk("t6_stall", sym_ready, HALT_EN ? 0 : 1);
        rpt_ready = 1'b1;
        @(negedge clk);
        chk("t6_resume", sym_ready, 1);
        chk("t6_done", rpt_valid, 0);

        // Timestamp wrap at 0xFFFF
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        wait_ready("t5");
        sym_valid = 1'b1;
        sym_data = 8'h00;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        sym_data = 8'h73;
        @(posedge clk);
        @(negedge clk);
        sym_data = 8'h72;
        @(posedge clk);
        @(negedge clk);
        sym_valid = 1'b0;
        wait_rpt("t5");
        chk("t5_id1", rpt_id, 1);
        chk("t5_ts_ffff", rpt_ts, 16'hFFFF);
        @(negedge clk);
        chk("t5_v7", rpt_valid, 1);
        chk("t5_id7", rpt_id, 7);
        chk("t5_ts_wrap", rpt_ts, 16'h0000);
        @(negedge clk);
        chk("t5_done", rpt_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
